// File: rtl/counter_seq.sv
// counter_seq - LOAD/STEP/RUN/NOP command sequencer driving an up/down load counter.
// Revision 1.0
`default_nettype none

module counter_seq #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_dir,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   output logic              load_n,
   output logic [WIDTH-1:0]  data_load,
   output logic              ce,
   output logic              up_down,
   input  logic              max_count,
   input  logic              zero,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] wraps,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_STEP = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam logic [1:0]        c_OP_LOAD      = 2'b00;
   localparam logic [1:0]        c_OP_STEP      = 2'b01;
   localparam logic [1:0]        c_OP_RUN       = 2'b10;
   localparam logic [STEP_W-1:0] c_ONE_STEP     = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]    c_TIMEOUT_LAST = {1'b0, {WIDTH{1'b1}}};

   state_t              r_state;
   logic [STEP_W-1:0]   r_remain;
   logic [WIDTH:0]      r_tcnt;
   logic                r_ce;
   logic                r_load_n;
   logic                r_up_down;
   logic [WIDTH-1:0]    r_data_load;
   logic                r_done;
   logic [STEP_W-1:0]   r_wraps;
   logic                r_err;

   logic                w_accept;
   logic                w_bound;
   logic                w_run_ce;
   logic                w_wrap;

   assign w_accept = cmd_valid && (r_state == S_IDLE);
   assign w_bound  = r_up_down ? max_count : zero;

   // RUN enables the counter straight from the bound flag so it stops on the exact cycle.
   assign w_run_ce = (r_state == S_RUN) && !w_bound && !r_tcnt[WIDTH];
   assign w_wrap   = (r_state == S_STEP) && r_ce && w_bound;

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign load_n    = r_load_n;
   assign data_load = r_data_load;
   assign ce        = r_ce || w_run_ce;
   assign up_down   = r_up_down;
   assign done      = r_done;
   assign wraps     = r_wraps;
   assign err       = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remain    <= '0;
         r_tcnt      <= '0;
         r_ce        <= 1'b0;
         r_load_n    <= 1'b1;
         r_up_down   <= 1'b1;
         r_data_load <= '0;
         r_done      <= 1'b0;
         r_wraps     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_load_n <= 1'b1;
         r_ce     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_wraps <= '0;
                  r_err   <= 1'b0;
                  case (cmd_op)
                     c_OP_LOAD: begin
                        r_data_load <= cmd_data;
                        r_load_n    <= 1'b0;
                        r_state     <= S_LOAD;
                     end
                     c_OP_STEP: begin
                        r_up_down <= cmd_dir;
                        if (cmd_steps == '0) begin
                           r_done <= 1'b1;
                        end else begin
                           r_remain <= cmd_steps;
                           r_ce     <= 1'b1;
                           r_state  <= S_STEP;
                        end
                     end
                     c_OP_RUN: begin
                        r_up_down <= cmd_dir;
                        r_tcnt    <= '0;
                        r_state   <= S_RUN;
                     end
                     default: begin
                        r_done <= 1'b1;
                     end
                  endcase
               end
            end
            S_LOAD: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            S_STEP: begin
               if (w_wrap && !(&r_wraps)) begin
                  r_wraps <= r_wraps + c_ONE_STEP;
               end
               if (r_remain == c_ONE_STEP) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_remain <= r_remain - c_ONE_STEP;
                  r_ce     <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_bound) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else if (w_run_ce) begin
                  r_tcnt <= r_tcnt + 1'b1;
                  // Last permitted enable cycle: the counter never reached its bound.
                  if (r_tcnt == c_TIMEOUT_LAST) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_counter_seq.sv
// tb_counter_seq - directed test of counter_seq driving a behavioural up/down load counter.
// Revision 1.0
`default_nettype none

module tb_counter_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_dir;
   logic [3:0] cmd_data;
   logic [7:0] cmd_steps;
   logic       load_n;
   logic [3:0] data_load;
   logic       ce;
   logic       up_down;
   logic       max_count;
   logic       zero;
   logic       busy;
   logic       done;
   logic [7:0] wraps;
   logic       err;

   logic       cnt_rst_n;
   logic [3:0] cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int ov_total = 0;

   always #5 clk = ~clk;

   counter_seq #(.WIDTH(4), .STEP_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dir   (cmd_dir),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .load_n    (load_n),
      .data_load (data_load),
      .ce        (ce),
      .up_down   (up_down),
      .max_count (max_count),
      .zero      (zero),
      .busy      (busy),
      .done      (done),
      .wraps     (wraps),
      .err       (err)
   );

   // Behavioural up/down load counter with its own synchronous active-low reset.
   always @(posedge clk) begin
      if (!cnt_rst_n)  cnt <= 4'd0;
      else if (!load_n) cnt <= data_load;
      else if (ce)     cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
   end
   assign max_count = (cnt == 4'hF);
   assign zero      = (cnt == 4'h0);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one command from a negedge; return the cycle (relative to accept edge k) of done.
   task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] data,
                          input logic [7:0] steps, output int j, output int ce_n, output int ln_n);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dir   = dir;
      cmd_data  = data;
      cmd_steps = steps;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      j    = 1;
      ce_n = 0;
      ln_n = 0;
      forever begin
         if (ce) ce_n++;
         if (!load_n) ln_n++;
         if (ce && !load_n) ov_total++;
         if (done || j >= 200) break;
         @(negedge clk);
         j++;
      end
      check_val("done_seen", {31'd0, done}, 32'd1);
   endtask

   int  j, ce_n, ln_n;
   logic saw_done;

   initial begin
      rst = 1'b1; cnt_rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'b11; cmd_dir = 1'b0; cmd_data = 4'd0; cmd_steps = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_load_n",    {31'd0, load_n},    32'd1);
      check_val("rst_ce",        {31'd0, ce},        32'd0);
      check_val("rst_up_down",   {31'd0, up_down},   32'd1);
      check_val("rst_data_load", {28'd0, data_load}, 32'd0);
      check_val("rst_done",      {31'd0, done},      32'd0);
      check_val("rst_busy",      {31'd0, busy},      32'd0);
      check_val("rst_wraps",     {24'd0, wraps},     32'd0);
      check_val("rst_err",       {31'd0, err},       32'd0);
      check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      rst = 1'b0; cnt_rst_n = 1'b1;
      @(negedge clk);

      // LOAD 0xA
      run_cmd(2'b00, 1'b1, 4'hA, 8'd0, j, ce_n, ln_n);
      check_val("load_done_cyc", j, 32'd2);
      check_val("load_ln_cycles", ln_n, 32'd1);
      check_val("load_ce_cycles", ce_n, 32'd0);
      check_val("load_count", {28'd0, cnt}, 32'd10);
      check_val("load_data", {28'd0, data_load}, 32'd10);
      check_val("load_wraps", {24'd0, wraps}, 32'd0);
      check_val("load_err", {31'd0, err}, 32'd0);

      // STEP up 3 from 10
      run_cmd(2'b01, 1'b1, 4'h0, 8'd3, j, ce_n, ln_n);
      check_val("step3_done_cyc", j, 32'd4);
      check_val("step3_ce", ce_n, 32'd3);
      check_val("step3_count", {28'd0, cnt}, 32'd13);
      check_val("step3_wraps", {24'd0, wraps}, 32'd0);

      // STEP up 5 from 13 wraps once through 15->0
      run_cmd(2'b01, 1'b1, 4'h0, 8'd5, j, ce_n, ln_n);
      check_val("step5_done_cyc", j, 32'd6);
      check_val("step5_ce", ce_n, 32'd5);
      check_val("step5_count", {28'd0, cnt}, 32'd2);
      check_val("step5_wraps", {24'd0, wraps}, 32'd1);

      // STEP down 20 from 2 passes zero twice
      run_cmd(2'b01, 1'b0, 4'h0, 8'd20, j, ce_n, ln_n);
      check_val("step20_done_cyc", j, 32'd21);
      check_val("step20_ce", ce_n, 32'd20);
      check_val("step20_count", {28'd0, cnt}, 32'd14);
      check_val("step20_wraps", {24'd0, wraps}, 32'd2);
      check_val("step20_up_down", {31'd0, up_down}, 32'd0);

      // STEP N=0 then NOP accepted in the same cycle as the first done
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dir = 1'b1; cmd_steps = 8'd0;
      @(posedge clk);
      @(negedge clk);
      check_val("step0_done", {31'd0, done}, 32'd1);
      check_val("step0_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("step0_ce", {31'd0, ce}, 32'd0);
      check_val("step0_busy", {31'd0, busy}, 32'd0);
      cmd_op = 2'b11;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("nop_done", {31'd0, done}, 32'd1);
      check_val("nop_ce", {31'd0, ce}, 32'd0);
      @(negedge clk);
      check_val("nop_done_pulse", {31'd0, done}, 32'd0);
      check_val("b2b_count", {28'd0, cnt}, 32'd14);

      // RUN down from 3 stops at zero
      run_cmd(2'b00, 1'b1, 4'h3, 8'd0, j, ce_n, ln_n);
      run_cmd(2'b10, 1'b0, 4'h0, 8'd0, j, ce_n, ln_n);
      check_val("rundn_done_cyc", j, 32'd5);
      check_val("rundn_ce", ce_n, 32'd3);
      check_val("rundn_count", {28'd0, cnt}, 32'd0);
      check_val("rundn_zero", {31'd0, zero}, 32'd1);
      check_val("rundn_err", {31'd0, err}, 32'd0);

      // RUN up already at 15: no enable cycles
      run_cmd(2'b00, 1'b1, 4'hF, 8'd0, j, ce_n, ln_n);
      run_cmd(2'b10, 1'b1, 4'h0, 8'd0, j, ce_n, ln_n);
      check_val("runup_bound_done_cyc", j, 32'd2);
      check_val("runup_bound_ce", ce_n, 32'd0);
      check_val("runup_bound_count", {28'd0, cnt}, 32'd15);

      // RUN up with counter held in reset: timeout
      cnt_rst_n = 1'b0;
      run_cmd(2'b10, 1'b1, 4'h0, 8'd0, j, ce_n, ln_n);
      check_val("timeout_done_cyc", j, 32'd17);
      check_val("timeout_ce", ce_n, 32'd16);
      check_val("timeout_err", {31'd0, err}, 32'd1);
      cnt_rst_n = 1'b1;
      @(negedge clk);
      check_val("timeout_err_hold", {31'd0, err}, 32'd1);

      // Reset in the middle of STEP 50
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dir = 1'b1; cmd_steps = 8'd50;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("abort_err_clr", {31'd0, err}, 32'd0);
      check_val("abort_busy", {31'd0, busy}, 32'd1);
      check_val("abort_ce", {31'd0, ce}, 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("abort_ce_off", {31'd0, ce}, 32'd0);
      check_val("abort_busy_off", {31'd0, busy}, 32'd0);
      check_val("abort_ready", {31'd0, cmd_ready}, 32'd1);
      saw_done = done;
      repeat (5) begin
         @(negedge clk);
         saw_done = saw_done | done;
      end
      check_val("abort_no_done", {31'd0, saw_done}, 32'd0);
      check_val("abort_count_kept", {28'd0, cnt}, 32'd6);
      check_val("no_load_ce_overlap", ov_total, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/counter_seq.md
Name: counter_seq

Overview:
- Command sequencer directly upstream of the up/down load counter.
- Accepts LOAD / STEP / RUN / NOP commands on a valid/ready interface and drives the counter controls: load_n, data_load, ce, up_down.
- Reads the counter's max_count and zero flags to stop RUN commands at a bound and to count wrap-arounds during STEP commands.
- Reports completion with a one-cycle done pulse, a wrap count and an error flag.

Parameters:
- WIDTH, 4, counter width; must match the driven counter.
- STEP_W, 8, width of the step-count field and of the wraps output.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 STEP, 10 RUN, 11 NOP.
- cmd_dir  in  1  1 = up, 0 = down; used by STEP and RUN.
- cmd_data  in  WIDTH  load value; used by LOAD.
- cmd_steps  in  STEP_W  number of counting cycles; used by STEP.
- load_n  out  1  to counter; active-low load.
- data_load  out  WIDTH  to counter; load value.
- ce  out  1  to counter; count enable.
- up_down  out  1  to counter; 1 = up.
- max_count  in  1  from counter; count is all ones.
- zero  in  1  from counter; count is 0.
- busy  out  1  command in progress (state not IDLE).
- done  out  1  one-cycle pulse when a command completes.
- wraps  out  STEP_W  wrap events during the last command; saturating.
- err  out  1  last RUN timed out; valid from done until the next accept.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs: load_n=1, ce=0, up_down=1, data_load=0, done=0, busy=0, wraps=0, err=0, cmd_ready=1.
  - Reset overrides everything, including mid-command: the command is aborted, no done pulse is produced, and the counter value is left as is.
- FSM states: IDLE, LOAD, STEP, RUN.
- Accept: cmd_valid && cmd_ready at edge k.
  - Captures op, dir, data and steps.
  - Clears wraps and err.
  - up_down takes the captured direction and holds it until the next STEP/RUN accept.
  - data_load takes cmd_data only on a LOAD accept and holds otherwise.
- LOAD:
  - Cycle k+1 is state LOAD with load_n=0 and ce=0.
  - Counter holds the value at edge k+2.
  - State returns to IDLE at k+2 with done=1.
- STEP with N = cmd_steps:
  - N = 0: no ce cycles; returns to IDLE with done=1 in cycle k+1.
  - N > 0: ce=1 in exactly cycles k+1..k+N (down-counter of remaining steps); IDLE with done=1 in cycle k+N+1.
  - The counter wraps freely.
  - A wrap event is a cycle with ce=1 and either (up_down=1 and max_count=1) or (up_down=0 and zero=1).
  - Each wrap event increments wraps; wraps saturates at all ones.
- RUN:
  - Bound flag: max_count if dir=1, zero if dir=0.
  - In RUN, ce = !bound, combinationally from the flag. This is the only input-to-output combinational path.
  - When bound=1 is seen in RUN, the state goes to IDLE with done=1 in the next cycle.
  - If bound is already 1 at the first RUN cycle, there are zero ce cycles and done comes at k+2.
  - Timeout:
    - A WIDTH+1-bit counter counts ce cycles.
    - If it reaches 2^WIDTH without bound (e.g. the counter is held in reset), ce drops.
    - The state goes to IDLE with done=1 and err=1.
- NOP: no counter activity; done=1 in cycle k+1.
- Outside LOAD: load_n=1. Outside STEP/RUN: ce=0.
- load_n=0 and ce=1 are never asserted in the same cycle.
- done is high for exactly one cycle, coincident with the first IDLE cycle. In that cycle cmd_ready=1, so back-to-back accept is allowed.
- cmd_valid is ignored while busy, and commands are never queued.

Test Plan (WIDTH=4, STEP_W=8, counter reset to 0):
- LOAD data=4'hA accepted at k -> load_n=0 only in k+1; count_out=10 and done=1 in k+2; wraps=0, err=0.
- STEP up N=3 from 10 -> ce high exactly 3 cycles; count_out=13; wraps=0; done at k+4.
- STEP up N=5 from 13 -> count_out=2; wraps=1 (wrap at 15->0); done at k+6. Then STEP down N=20 from 2 -> count_out=14; wraps=2.
- STEP N=0, then NOP, back-to-back -> no ce; each done at k+1; second command accepted in the same cycle as the first done.
- RUN down from 3 -> ce exactly 3 cycles, zero=1, count_out=0, done, err=0. Then RUN up with count at 15 -> zero ce cycles, done at k+2.
- RUN up with counter rst_n held low -> 16 ce cycles, then done with err=1.
- rst=1 during STEP N=50 -> ce=0, busy=0, cmd_ready=1 next cycle, no done pulse.
